vector_dispatch_ctrl: RTL and testbench

VECTOR_DISPATCH_CTRL -- requirements
Module: vector_dispatch_ctrl

---
 rtl/vector_pkg.sv | 23 ++
 rtl/vector_elem_sel.sv | 31 +++
 rtl/vector_dispatch_ctrl.sv | 147 ++++++++++++++
 tb/tb_vector_dispatch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// -----------------------------------------------------------------------------
// vector_pkg
// Shared definitions for the vector dispatch block:
//   FP_W       - width of one floating-point element (32)
//   state_e    - dispatch FSM states (IDLE / RUN / DONE)
//   is_fp_zero - true for +0.0 and -0.0 (sign bit ignored)
// -----------------------------------------------------------------------------
package vector_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Both signed zeros count as zero, so only the magnitude bits are tested.
    function automatic logic is_fp_zero(input logic [FP_W-1:0] x);
        return (x[FP_W-2:0] == '0);
    endfunction

endpackage

// File: rtl/vector_elem_sel.sv
// -----------------------------------------------------------------------------
// vector_elem_sel
// Purely combinational element picker: returns element idx of a packed vector.
// Ports:
//   vec  [FP_W*VLEN-1:0] in  packed vector, element i = vec[FP_W*i +: FP_W]
//   idx  [IDX_W-1:0]     in  element index
//   elem [FP_W-1:0]      out selected element (0 for an out-of-range index)
// -----------------------------------------------------------------------------
module vector_elem_sel
    import vector_pkg::*;
#(
    parameter  int VLEN  = 4,
    localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic [FP_W*VLEN-1:0] vec,
    input  logic [IDX_W-1:0]     idx,
    output logic [FP_W-1:0]      elem
);

    // Loop-based mux keeps indices that exceed VLEN-1 (non power-of-two VLEN)
    // well defined.
    always_comb begin
        elem = '0;
        for (int i = 0; i < VLEN; i++) begin
            if (idx == IDX_W'(i)) begin
                elem = vec[FP_W*i +: FP_W];
            end
        end
    end

endmodule

// File: rtl/vector_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// vector_dispatch_ctrl
// Captures a packed vector of VLEN FP32 elements on start and streams it out
// one element per beat over a valid/ready interface, then pulses done.
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready are
// both high. out_valid never depends on out_ready, and while out_valid is high
// without a transfer, out_data/out_idx/out_last stay stable.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   dispatch request, only looked at in IDLE
//   abort      in   synchronous cancel while in RUN (wins over a transfer)
//   vec        in   packed vector, element i = vec[32*i +: 32]
//   busy       out  high in RUN and DONE
//   done       out  one-cycle pulse after the final beat
//   out_data   out  current element
//   out_idx    out  index of out_data within the vector
//   out_valid  out  beat valid
//   out_ready  in   downstream accepts the beat
//   out_last   out  current beat is the final one
//   state_dbg  out  raw FSM state for observation
//
// Build option: define VECTOR_DISPATCH_SKIP_ZERO_EN to skip +0/-0 elements
// (one idle cycle per skipped element, out_last on the last nonzero element).
// -----------------------------------------------------------------------------
module vector_dispatch_ctrl
    import vector_pkg::*;
#(
    parameter  int VLEN  = 4,
    localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [FP_W*VLEN-1:0] vec,
    output logic                 busy,
    output logic                 done,
    output logic [FP_W-1:0]      out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [FP_W*VLEN-1:0] captured;
    logic [FP_W-1:0]      elem;
    logic                 run_st;
    logic                 fire;

    vector_elem_sel #(.VLEN(VLEN)) u_elem_sel (
        .vec  (captured),
        .idx  (idx),
        .elem (elem)
    );

    assign run_st = (state == ST_RUN);

`ifdef VECTOR_DISPATCH_SKIP_ZERO_EN
    logic elem_zero;
    logic more_above;

    assign elem_zero = is_fp_zero(elem);

    // Lookahead: is there any nonzero element at an index above idx?
    always_comb begin
        more_above = 1'b0;
        for (int i = 0; i < VLEN; i++) begin
            if ((i > int'(idx)) && !is_fp_zero(captured[FP_W*i +: FP_W])) begin
                more_above = 1'b1;
            end
        end
    end

    assign out_valid = run_st & ~elem_zero;
    assign out_last  = run_st & ~elem_zero & ~more_above;
`else
    assign out_valid = run_st;
    assign out_last  = run_st & (idx == IDX_W'(VLEN - 1));
`endif

    assign fire      = out_valid & out_ready;
    assign out_data  = elem;
    assign out_idx   = idx;
    assign busy      = (state == ST_RUN) | (state == ST_DONE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            captured <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        captured <= vec;
                        idx      <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        idx   <= '0;
                        state <= ST_IDLE;
                    end else if (fire) begin
                        if (out_last) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
`ifdef VECTOR_DISPATCH_SKIP_ZERO_EN
                    else if (elem_zero) begin
                        // Skipped element: move on, or finish if nothing
                        // nonzero remains (covers the all-zero vector).
                        if (more_above) begin
                            idx <= idx + IDX_W'(1);
                        end else begin
                            state <= ST_DONE;
                        end
                    end
`endif
                end
                ST_DONE: begin
                    idx   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    idx   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vector_dispatch_ctrl
// Self-checking bench for vector_dispatch_ctrl (VLEN = 4). Expected beats are
// pushed to exp_q when a vector is started and popped by the monitor on every
// transfer. Works with or without VECTOR_DISPATCH_SKIP_ZERO_EN.
// -----------------------------------------------------------------------------
module tb_vector_dispatch_ctrl;

    localparam int VLEN  = 4;
    localparam int IDX_W = 2;
    localparam int W     = IDX_W + 1 + 32;   // {idx, last, data}

`ifdef VECTOR_DISPATCH_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [32*VLEN-1:0] vec;
    logic               busy;
    logic               done;
    logic [31:0]        out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [1:0]         state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vector_dispatch_ctrl #(.VLEN(VLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec       (vec),
        .busy      (busy),
        .done      (done),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           checks   = 0;
    int           errors   = 0;
    int           done_cnt = 0;
    logic         prev_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32*VLEN-1:0] mkvec(input logic [31:0] e0, input logic [31:0] e1,
                                                 input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    // Reference model: which elements are emitted and which one is last.
    task automatic push_expected(input logic [32*VLEN-1:0] v);
        int          last_i;
        logic [31:0] el;
        last_i = -1;
        for (int i = 0; i < VLEN; i++) begin
            el = v[32*i +: 32];
            if (!SKIP || (el[30:0] != 31'd0)) last_i = i;
        end
        for (int i = 0; i < VLEN; i++) begin
            el = v[32*i +: 32];
            if (!SKIP || (el[30:0] != 31'd0)) begin
                exp_q.push_back({IDX_W'(i), (i == last_i), el});
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (rst_n) begin
            act = {out_idx, out_last, out_data};
            if (out_valid && out_ready && !abort) begin
                // With nothing queued no beat is legal: compare against the
                // complement so the mismatch is reported with the beat value.
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~act;
                check("beat", act, exp);
            end
            if (done) begin
                done_cnt++;
                check("done_one_cycle", prev_done, 0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [32*VLEN-1:0] v);
        @(posedge clk);
        #1;
        start = 1'b1;
        vec   = v;
        push_expected(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!SKIP || (v[30:0] != 31'd0)) begin
            check("first_valid", out_valid, 1);
            check("first_idx", out_idx, 0);
        end
    endtask

    task automatic wait_done(input string tag);
        int base;
        int n;
        base = done_cnt;
        n    = 0;
        while (done_cnt == base && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, done_cnt - base, 1);
        check({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [32*VLEN-1:0] v1;
        logic [32*VLEN-1:0] v2;
        logic [32*VLEN-1:0] vr;
        int                 base;
        int                 n;

        v1 = mkvec(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        v2 = mkvec(32'h4120_0000, 32'hBF80_0000, 32'h4248_0000, 32'hC000_0000);

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        vec       = '1;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: straight stream, then start during DONE must be ignored
        do_start(v1);
        repeat (4) @(negedge clk);
        #1;
        check("t1_four_beats", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 1);
        start = 1'b1;
        vec   = v2;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t1_start_in_done_ignored", busy, 0);
        check("t1_idle_valid", out_valid, 0);
        check("t1_done_cleared", done, 0);

        // T2: back-pressure for 3 cycles at idx 1
        do_start(v1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t2_hold_idx", out_idx, 1);
            check("t2_hold_data", out_data, 32'h4000_0000);
            check("t2_hold_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done("t2");

        // T3: input vector changes right after capture
        do_start(v1);
        vec = '1;
        wait_done("t3");

        // T4: abort together with ready at idx 2, then restart
        do_start(v1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t4_idx2", out_idx, 2);
        base  = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_valid", out_valid, 0);
        check("t4_abort_left", exp_q.size(), 2);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        check("t4_no_done", done_cnt, base);
        abort = 1'b1;            // abort in IDLE alongside start: no effect
        do_start(v2);
        abort = 1'b0;
        wait_done("t4_restart");

        // T5: async reset mid-dispatch, start held through release
        do_start(v1);
        @(posedge clk);
        #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_idx", out_idx, 0);
        check("t5_rst_last", out_last, 0);
        exp_q.delete();
        base  = done_cnt;
        start = 1'b1;
        vec   = v2;
        push_expected(v2);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t5_first_edge_accept", out_valid, 1);
        check("t5_no_done", done_cnt, base);
        wait_done("t5");

        // T6: zero elements (skipped only when the option is built in)
        do_start(mkvec(32'h0000_0000, 32'h3F80_0000, 32'h8000_0000, 32'h4000_0000));
        wait_done("t6_mixed");
        do_start('0);
        wait_done("t6_allzero");

        // T7: random vectors with random back-pressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < VLEN; i++) begin
                vr[32*i +: 32] = ($urandom_range(0, 2) == 0) ? 32'h8000_0000 * $urandom_range(0, 1)
                                                            : $urandom;
            end
            do_start(vr);
            base = done_cnt;
            n    = 0;
            while (done_cnt == base && n < 80) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
                n++;
            end
            out_ready = 1'b1;
            check("t7_done", done_cnt - base, 1);
            check("t7_drained", exp_q.size(), 0);
            exp_q.delete();
            repeat (2) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
